// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pll_reset_sequencer
// Purpose  : PLL reset/lock controller with lock qualification, timeout/retry
//            and staged release of downstream domain resets.
// Revision : 1.0 - initial release
// ============================================================================
module pll_reset_sequencer #(
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 5000000,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int STAGES              = 3,
  parameter int STAGE_GAP           = 16,
  parameter int CNT_W               = 8
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              pll_locked,
  input  logic              force_relock,
  output logic              pll_rst,
  output logic [STAGES-1:0] rst_out,
  output logic              ready,
  output logic [CNT_W-1:0]  relock_count,
  output logic              lost_lock,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    PLL_RESET = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One shared timer serves every state, so size it for the longest interval.
  localparam int c_timer_max = max2(max2(LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES),
                                    max2(PLL_RST_CYCLES, STAGE_GAP * STAGES));
  localparam int c_timer_w   = $clog2(c_timer_max + 1);

  state_t               r_state;
  logic [c_timer_w-1:0] r_timer;
  logic [1:0]           r_sync;
  logic                 w_locked_s;

  state_t               w_state_n;
  logic [c_timer_w-1:0] w_timer_n;
  logic [c_timer_w-1:0] w_timer_inc;
  logic                 w_pll_rst_n;
  logic [STAGES-1:0]    w_rst_out_n;
  logic                 w_ready_n;
  logic                 w_lost_n;
  logic                 w_count_inc;
  logic                 w_lock_lost;
  logic [CNT_W-1:0]     w_relock_n;

  assign w_locked_s  = r_sync[1];
  assign w_timer_inc = r_timer + c_timer_w'(1);
  assign w_lock_lost = ((r_state == RELEASE) || (r_state == RUN)) && !w_locked_s;
  assign state       = r_state;

  always_comb begin
    w_state_n   = r_state;
    w_timer_n   = r_timer;
    w_pll_rst_n = pll_rst;
    w_rst_out_n = rst_out;
    w_ready_n   = ready;
    w_lost_n    = 1'b0;
    w_count_inc = 1'b0;

    case (r_state)
      PLL_RESET: begin
        w_pll_rst_n = 1'b1;
        w_rst_out_n = '1;
        w_ready_n   = 1'b0;
        if (r_timer == c_timer_w'(PLL_RST_CYCLES - 1)) begin
          w_state_n   = WAIT_LOCK;
          w_pll_rst_n = 1'b0;
          w_timer_n   = '0;
        end else begin
          w_timer_n = w_timer_inc;
        end
      end

      WAIT_LOCK: begin
        if (w_locked_s) begin
          w_state_n = STABLE;
          w_timer_n = '0;
        end else if (r_timer == c_timer_w'(LOCK_TIMEOUT_CYCLES - 1)) begin
          w_state_n   = PLL_RESET;
          w_pll_rst_n = 1'b1;
          w_timer_n   = '0;
          w_count_inc = 1'b1;
        end else begin
          w_timer_n = w_timer_inc;
        end
      end

      STABLE: begin
        if (!w_locked_s) begin
          w_state_n = WAIT_LOCK;
          w_timer_n = '0;
        end else if (r_timer == c_timer_w'(LOCK_STABLE_CYCLES)) begin
          w_timer_n      = '0;
          w_rst_out_n[0] = 1'b0;
          if (STAGES == 1) begin
            w_state_n = RUN;
            w_ready_n = 1'b1;
          end else begin
            w_state_n = RELEASE;
          end
        end else begin
          w_timer_n = w_timer_inc;
        end
      end

      RELEASE: begin
        // Timer counts cycles since rst_out[0] fell; stage i drops at GAP*i.
        w_timer_n = w_timer_inc;
        for (int i = 1; i < STAGES; i++) begin
          if (w_timer_inc == c_timer_w'(STAGE_GAP * i)) begin
            w_rst_out_n[i] = 1'b0;
          end
        end
        if (w_timer_inc == c_timer_w'(STAGE_GAP * (STAGES - 1))) begin
          w_state_n = RUN;
          w_ready_n = 1'b1;
        end
      end

      RUN: begin
        w_timer_n = '0;
      end

      default: begin
        w_state_n = PLL_RESET;
        w_timer_n = '0;
      end
    endcase

    if (w_lock_lost) begin
      w_state_n   = WAIT_LOCK;
      w_timer_n   = '0;
      w_rst_out_n = '1;
      w_ready_n   = 1'b0;
      w_lost_n    = 1'b1;
      w_count_inc = 1'b1;
    end

    // A relock request overrides everything else but still lets a
    // simultaneous lock loss be reported and counted.
    if (force_relock && (r_state != PLL_RESET)) begin
      w_state_n   = PLL_RESET;
      w_timer_n   = '0;
      w_pll_rst_n = 1'b1;
      w_rst_out_n = '1;
      w_ready_n   = 1'b0;
    end
  end

  assign w_relock_n = (w_count_inc && (relock_count != '1))
                    ? relock_count + CNT_W'(1) : relock_count;

  // Lock seen before or during a PLL reset is stale, so the synchronizer is
  // flushed while pll_rst is asserted.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_state      <= PLL_RESET;
      r_timer      <= '0;
      r_sync       <= '0;
      pll_rst      <= 1'b1;
      rst_out      <= '1;
      ready        <= 1'b0;
      relock_count <= '0;
      lost_lock    <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_timer      <= w_timer_n;
      r_sync       <= pll_rst ? 2'b00 : {r_sync[0], pll_locked};
      pll_rst      <= w_pll_rst_n;
      rst_out      <= w_rst_out_n;
      ready        <= w_ready_n;
      relock_count <= w_relock_n;
      lost_lock    <= w_lost_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_reset_sequencer
// Purpose  : Directed self-checking bench for pll_reset_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pll_reset_sequencer;
  localparam int LSC = 8, LTC = 64, PRC = 4, ST = 3, GAP = 2, CW = 8;

  logic          refclk = 1'b0;
  logic          rst, pll_locked, force_relock;
  logic          pll_rst, ready, lost_lock;
  logic [ST-1:0] rst_out;
  logic [CW-1:0] relock_count;
  logic [2:0]    state;
  int            n_checks = 0;
  int            n_pass   = 0;

  pll_reset_sequencer #(
    .LOCK_STABLE_CYCLES(LSC), .LOCK_TIMEOUT_CYCLES(LTC), .PLL_RST_CYCLES(PRC),
    .STAGES(ST), .STAGE_GAP(GAP), .CNT_W(CW)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .force_relock(force_relock),
    .pll_rst(pll_rst), .rst_out(rst_out), .ready(ready), .relock_count(relock_count),
    .lost_lock(lost_lock), .state(state)
  );

  always #5 refclk = ~refclk;

  task automatic step(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  // Holds rst for a few edges, checks reset values, releases rst (edge 0).
  task automatic test_reset(input logic lk);
    rst = 1'b1; pll_locked = lk; force_relock = 1'b0;
    step(3);
    n_checks++;
    if ({state, pll_rst, rst_out, ready, lost_lock} !== {3'd0, 1'b1, 3'b111, 1'b0, 1'b0})
      $display("FAIL reset_outputs: state=%0d pll_rst=%b rst_out=%b ready=%b lost=%b, expected 0 1 111 0 0",
               state, pll_rst, rst_out, ready, lost_lock);
    else n_pass++;
    n_checks++;
    if (relock_count !== 8'd0) $display("FAIL reset_count: got %0d expected 0", relock_count);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_power_up();
    logic [2:0] e_state, e_rst;
    logic e_pll, e_ready;
    for (int k = 1; k <= 24; k++) begin
      step(1);
      e_state = (k < 4) ? 3'd0 : (k < 7) ? 3'd1 : (k < 16) ? 3'd2 : (k < 20) ? 3'd3 : 3'd4;
      e_rst   = (k < 16) ? 3'b111 : (k < 18) ? 3'b110 : (k < 20) ? 3'b100 : 3'b000;
      e_pll   = (k < 4);
      e_ready = (k >= 20);
      n_checks++;
      if ({state, rst_out, pll_rst, ready} !== {e_state, e_rst, e_pll, e_ready})
        $display("FAIL power_up edge %0d: state=%0d rst_out=%b pll_rst=%b ready=%b, expected %0d %b %b %b",
                 k, state, rst_out, pll_rst, ready, e_state, e_rst, e_pll, e_ready);
      else n_pass++;
    end
    n_checks++;
    if (relock_count !== 8'd0) $display("FAIL power_up_count: got %0d expected 0", relock_count);
    else n_pass++;
  endtask

  task automatic test_lock_loss();
    pll_locked = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      step(1);
      n_checks++;
      if ({state, ready} !== {3'd4, 1'b1})
        $display("FAIL lock_loss_hold edge %0d: state=%0d ready=%b, expected 4 1", k, state, ready);
      else n_pass++;
    end
    step(1);
    n_checks++;
    if ({state, rst_out, ready, lost_lock, pll_rst} !== {3'd1, 3'b111, 1'b0, 1'b1, 1'b0})
      $display("FAIL lock_loss_react: state=%0d rst_out=%b ready=%b lost=%b pll_rst=%b, expected 1 111 0 1 0",
               state, rst_out, ready, lost_lock, pll_rst);
    else n_pass++;
    n_checks++;
    if (relock_count !== 8'd1) $display("FAIL lock_loss_count: got %0d expected 1", relock_count);
    else n_pass++;
    step(1);
    n_checks++;
    if ({state, lost_lock, pll_rst} !== {3'd1, 1'b0, 1'b0})
      $display("FAIL lock_loss_pulse: state=%0d lost=%b pll_rst=%b, expected 1 0 0", state, lost_lock, pll_rst);
    else n_pass++;
    pll_locked = 1'b1;
    step(11);
    n_checks++;
    if (rst_out !== 3'b111) $display("FAIL relock_early: rst_out=%b expected 111", rst_out);
    else n_pass++;
    step(1);
    n_checks++;
    if (rst_out !== 3'b110) $display("FAIL relock_stage0: rst_out=%b expected 110", rst_out);
    else n_pass++;
    step(4);
    n_checks++;
    if ({state, ready, rst_out} !== {3'd4, 1'b1, 3'b000})
      $display("FAIL relock_run: state=%0d ready=%b rst_out=%b, expected 4 1 000", state, ready, rst_out);
    else n_pass++;
  endtask

  task automatic test_force_relock();
    logic [2:0] e_rst;
    force_relock = 1'b1;
    step(1);
    force_relock = 1'b0;
    n_checks++;
    if ({state, pll_rst, rst_out, ready, relock_count} !== {3'd0, 1'b1, 3'b111, 1'b0, 8'd1})
      $display("FAIL force_enter: state=%0d pll_rst=%b rst_out=%b ready=%b count=%0d, expected 0 1 111 0 1",
               state, pll_rst, rst_out, ready, relock_count);
    else n_pass++;
    for (int k = 2; k <= 21; k++) begin
      step(1);
      e_rst = (k < 17) ? 3'b111 : (k < 19) ? 3'b110 : (k < 21) ? 3'b100 : 3'b000;
      n_checks++;
      if ({pll_rst, rst_out, ready} !== {(k < 5), e_rst, (k >= 21)})
        $display("FAIL force_reseq edge %0d: pll_rst=%b rst_out=%b ready=%b, expected %b %b %b",
                 k, pll_rst, rst_out, ready, (k < 5), e_rst, (k >= 21));
      else n_pass++;
    end
  endtask

  task automatic test_force_and_loss();
    pll_locked = 1'b0;
    step(2);
    n_checks++;
    if (state !== 3'd4) $display("FAIL both_pre: state=%0d expected 4", state);
    else n_pass++;
    force_relock = 1'b1;
    step(1);
    force_relock = 1'b0;
    n_checks++;
    if ({state, lost_lock, pll_rst, rst_out, ready, relock_count} !== {3'd0, 1'b1, 1'b1, 3'b111, 1'b0, 8'd2})
      $display("FAIL both_react: state=%0d lost=%b pll_rst=%b rst_out=%b ready=%b count=%0d, expected 0 1 1 111 0 2",
               state, lost_lock, pll_rst, rst_out, ready, relock_count);
    else n_pass++;
    step(1);
    n_checks++;
    if (lost_lock !== 1'b0) $display("FAIL both_pulse: lost=%b expected 0", lost_lock);
    else n_pass++;
  endtask

  task automatic test_timeout();
    logic [2:0] e_state;
    logic [7:0] e_cnt;
    logic e_pll, chk;
    test_reset(1'b0);
    for (int k = 1; k <= 137; k++) begin
      step(1);
      chk = 1'b1;
      case (k)
        4:       begin e_state = 3'd1; e_pll = 1'b0; e_cnt = 8'd0; end
        67:      begin e_state = 3'd1; e_pll = 1'b0; e_cnt = 8'd0; end
        68:      begin e_state = 3'd0; e_pll = 1'b1; e_cnt = 8'd1; end
        71:      begin e_state = 3'd0; e_pll = 1'b1; e_cnt = 8'd1; end
        72:      begin e_state = 3'd1; e_pll = 1'b0; e_cnt = 8'd1; end
        135:     begin e_state = 3'd1; e_pll = 1'b0; e_cnt = 8'd1; end
        136:     begin e_state = 3'd0; e_pll = 1'b1; e_cnt = 8'd2; end
        default: begin e_state = 3'd0; e_pll = 1'b0; e_cnt = 8'd0; chk = 1'b0; end
      endcase
      if (chk) begin
        n_checks++;
        if ({state, pll_rst, relock_count} !== {e_state, e_pll, e_cnt})
          $display("FAIL timeout edge %0d: state=%0d pll_rst=%b count=%0d, expected %0d %b %0d",
                   k, state, pll_rst, relock_count, e_state, e_pll, e_cnt);
        else n_pass++;
      end
    end
  endtask

  task automatic test_glitch();
    test_reset(1'b1);
    for (int k = 1; k <= 26; k++) begin
      step(1);
      if (k == 10) pll_locked = 1'b0;
      if (k == 13) pll_locked = 1'b1;
      n_checks++;
      if (rst_out !== ((k < 25) ? 3'b111 : 3'b110))
        $display("FAIL glitch_rst edge %0d: rst_out=%b expected %b", k, rst_out, (k < 25) ? 3'b111 : 3'b110);
      else n_pass++;
      if (k == 12 || k == 13 || k == 16 || k == 24) begin
        n_checks++;
        if (state !== ((k == 13) ? 3'd1 : 3'd2))
          $display("FAIL glitch_state edge %0d: state=%0d expected %0d", k, state, (k == 13) ? 1 : 2);
        else n_pass++;
      end
    end
    n_checks++;
    if (relock_count !== 8'd0) $display("FAIL glitch_count: got %0d expected 0", relock_count);
    else n_pass++;
  endtask

  task automatic test_saturate_and_reset();
    int budget;
    test_reset(1'b0);
    for (int k = 1; k <= 17408; k++) begin
      step(1);
      if (k == 17339 || k == 17340 || k == 17408) begin
        n_checks++;
        if (relock_count !== ((k == 17339) ? 8'd254 : 8'd255))
          $display("FAIL saturate edge %0d: count=%0d expected %0d", k, relock_count, (k == 17339) ? 254 : 255);
        else n_pass++;
      end
    end
    n_checks++;
    if (state !== 3'd0) $display("FAIL saturate_state: state=%0d expected 0", state);
    else n_pass++;
    pll_locked = 1'b1;
    budget = 0;
    while (state !== 3'd3 && budget < 100) begin
      step(1);
      budget++;
    end
    n_checks++;
    if ({state, rst_out, relock_count} !== {3'd3, 3'b110, 8'd255})
      $display("FAIL reach_release: state=%0d rst_out=%b count=%0d after %0d edges, expected 3 110 255",
               state, rst_out, relock_count, budget);
    else n_pass++;
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if ({state, pll_rst, rst_out, ready, relock_count, lost_lock} !== {3'd0, 1'b1, 3'b111, 1'b0, 8'd0, 1'b0})
      $display("FAIL async_reset: state=%0d pll_rst=%b rst_out=%b ready=%b count=%0d lost=%b, expected 0 1 111 0 0 0",
               state, pll_rst, rst_out, ready, relock_count, lost_lock);
    else n_pass++;
    step(1);
    rst = 1'b0;
  endtask

  initial begin
    test_reset(1'b1);
    test_power_up();
    test_lock_loss();
    test_force_relock();
    test_force_and_loss();
    test_timeout();
    test_glitch();
    test_saturate_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
